// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - fetch/EX inputs and predictor update bundle of branch_resolve
interface branch_resolve_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  CACHE_READY;
    logic                  CACHE_READY_DATA;
    logic                  IF_VALID;
    logic [ADDR_WIDTH-1:0] IF_PC;
    logic [ADDR_WIDTH-1:0] IF_PRD_ADDR;
    logic                  EX_VALID;
    logic [ADDR_WIDTH-1:0] EX_PC_IN;
    logic                  EX_IS_BRANCH;
    logic                  EX_TAKEN;
    logic [ADDR_WIDTH-1:0] EX_TARGET;
    logic                  EX_IS_RETURN;
    logic                  BRANCH;
    logic                  BRANCH_TAKEN;
    logic [ADDR_WIDTH-1:0] BRANCH_ADDR;
    logic [ADDR_WIDTH-1:0] EX_PC;
    logic                  RETURN;
    logic                  PREDICTED;
    logic                  FLUSH;
    logic                  SQUASH_EX;
    logic [31:0]           BRANCH_COUNT;
    logic [31:0]           MISPRED_COUNT;

    modport master (
        output CACHE_READY, CACHE_READY_DATA, IF_VALID, IF_PC, IF_PRD_ADDR,
               EX_VALID, EX_PC_IN, EX_IS_BRANCH, EX_TAKEN, EX_TARGET, EX_IS_RETURN,
        input  BRANCH, BRANCH_TAKEN, BRANCH_ADDR, EX_PC, RETURN, PREDICTED,
               FLUSH, SQUASH_EX, BRANCH_COUNT, MISPRED_COUNT
    );

    modport slave (
        input  CACHE_READY, CACHE_READY_DATA, IF_VALID, IF_PC, IF_PRD_ADDR,
               EX_VALID, EX_PC_IN, EX_IS_BRANCH, EX_TAKEN, EX_TARGET, EX_IS_RETURN,
        output BRANCH, BRANCH_TAKEN, BRANCH_ADDR, EX_PC, RETURN, PREDICTED,
               FLUSH, SQUASH_EX, BRANCH_COUNT, MISPRED_COUNT
    );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX-stage branch resolution against the carried prediction
// Drives the predictor update bundle and a fixed squash shadow after each mispredict.
module branch_resolve #(
    parameter int ADDR_WIDTH = 32,
    parameter int PIPE_DEPTH = 2,
    parameter int SHADOW     = 2
) (
    input  logic           CLK,
    input  logic           RST,
    branch_resolve_if.slave bus
);
    localparam int CW = (SHADOW < 2) ? 1 : $clog2(SHADOW + 1);
    localparam int HD = PIPE_DEPTH - 1;

    typedef enum logic {IDLE, SQUASH} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [PIPE_DEPTH-1:0] r_vld;
    logic [ADDR_WIDTH-1:0] r_pc  [PIPE_DEPTH];
    logic [ADDR_WIDTH-1:0] r_prd [PIPE_DEPTH];
    logic                  r_branch;
    logic                  r_taken;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_ex_pc;
    logic                  r_return;
    logic                  r_predicted;
    logic                  r_flush;
    logic [31:0]           r_bcnt;
    logic [31:0]           r_mcnt;

    logic                  w_adv;
    logic                  w_resolve;
    logic [ADDR_WIDTH-1:0] w_actual_next;
    logic                  w_mispred;

    assign w_adv         = bus.CACHE_READY & bus.CACHE_READY_DATA;
    assign w_resolve     = w_adv & bus.EX_VALID & (r_state == IDLE);
    assign w_actual_next = (bus.EX_IS_BRANCH & bus.EX_TAKEN) ? bus.EX_TARGET
                                                             : bus.EX_PC_IN + ADDR_WIDTH'(4);
    assign w_mispred     = w_resolve & (~r_vld[HD] | (r_pc[HD] != bus.EX_PC_IN)
                                        | (r_prd[HD] != w_actual_next));

    // Payload needs no reset: it is only ever consumed through r_vld.
    always_ff @(posedge CLK) begin
        if (w_adv) begin
            r_pc[0]  <= bus.IF_PC;
            r_prd[0] <= bus.IF_PRD_ADDR;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_pc[i]  <= r_pc[i-1];
                r_prd[i] <= r_prd[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld <= '0;
        end else if (w_mispred) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld[0] <= bus.IF_VALID;
            for (int i = 1; i < PIPE_DEPTH; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_branch    <= 1'b0;
            r_taken     <= 1'b0;
            r_addr      <= '0;
            r_ex_pc     <= '0;
            r_return    <= 1'b0;
            r_predicted <= 1'b1;
            r_flush     <= 1'b0;
            r_bcnt      <= '0;
            r_mcnt      <= '0;
        end else if (w_adv) begin
            if (w_resolve) begin
                r_ex_pc     <= bus.EX_PC_IN;
                r_branch    <= bus.EX_IS_BRANCH;
                r_taken     <= bus.EX_TAKEN & bus.EX_IS_BRANCH;
                r_addr      <= bus.EX_TARGET;
                r_return    <= bus.EX_IS_RETURN;
                r_predicted <= ~w_mispred;
                r_bcnt      <= r_bcnt + 32'(bus.EX_IS_BRANCH);
                if (w_mispred) begin
                    r_mcnt  <= r_mcnt + 32'(bus.EX_IS_BRANCH);
                    r_state <= SQUASH;
                    r_cnt   <= CW'(SHADOW);
                    r_flush <= 1'b1;
                end
            end else begin
                r_branch    <= 1'b0;
                r_predicted <= 1'b1;
                if (r_state == SQUASH) begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= IDLE;
                        r_flush <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.BRANCH        = r_branch;
    assign bus.BRANCH_TAKEN  = r_taken;
    assign bus.BRANCH_ADDR   = r_addr;
    assign bus.EX_PC         = r_ex_pc;
    assign bus.RETURN        = r_return;
    assign bus.PREDICTED     = r_predicted;
    assign bus.FLUSH         = r_flush;
    assign bus.SQUASH_EX     = (r_state == SQUASH);
    assign bus.BRANCH_COUNT  = r_bcnt;
    assign bus.MISPRED_COUNT = r_mcnt;
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit that closes the loop with the branch history table. It carries each fetched instruction's predicted next PC down a shift pipeline to EX, compares it with the actual branch outcome, and emits the per-cycle update bundle the predictor consumes: branch, taken, target, EX PC, prediction-correct, flush. On a misprediction it asserts the redirect and squashes younger in-flight instructions for a fixed shadow.

## Interface
- ADDR_WIDTH, 32, PC/address width
- PIPE_DEPTH, 2, stages between fetch-capture and EX (≥1)
- SHADOW, 2, younger instructions squashed after a mispredict (≥1)
- CLK  in  1  clock; all state on rising edge
- RST  in  1  reset, synchronous, active-high
- CACHE_READY  in  1  instruction cache ready
- CACHE_READY_DATA  in  1  data cache ready; advance = CACHE_READY & CACHE_READY_DATA
- IF_VALID  in  1  fetch slot holds a real instruction
- IF_PC  in  ADDR_WIDTH  fetched PC
- IF_PRD_ADDR  in  ADDR_WIDTH  predicted next PC for IF_PC
- EX_VALID  in  1  EX holds a real instruction
- EX_PC_IN  in  ADDR_WIDTH  PC of EX instruction
- EX_IS_BRANCH  in  1  EX instruction is branch/jump
- EX_TAKEN  in  1  resolved taken
- EX_TARGET  in  ADDR_WIDTH  resolved target
- EX_IS_RETURN  in  1  EX instruction is a return
- BRANCH  out  1  update strobe to predictor
- BRANCH_TAKEN  out  1  resolved direction
- BRANCH_ADDR  out  ADDR_WIDTH  resolved target
- EX_PC  out  ADDR_WIDTH  PC of resolved instruction
- RETURN  out  1  resolved instruction is a return
- PREDICTED  out  1  1 = prediction correct, 0 = mispredict/redirect
- FLUSH  out  1  high while squash shadow active
- SQUASH_EX  out  1  EX instruction this cycle must not retire
- BRANCH_COUNT  out  32  resolved branches since reset
- MISPRED_COUNT  out  32  mispredicts since reset

## Operation
- Shift pipeline of PIPE_DEPTH entries {valid, pc, prd}; on advance tail loads {IF_VALID, IF_PC, IF_PRD_ADDR}, head drops out; with no advance all entries hold.
- Head entry is aligned with EX inputs. Actual next PC: EX_IS_BRANCH & EX_TAKEN ? EX_TARGET : EX_PC_IN + 4 (modulo 2^ADDR_WIDTH).
- Resolve condition (advance, EX_VALID, state IDLE): mispredict if head.valid=0, head.pc ≠ EX_PC_IN, or head.prd ≠ actual next PC.
- On every resolve, register EX_PC←EX_PC_IN, BRANCH←EX_IS_BRANCH, BRANCH_TAKEN←EX_TAKEN&EX_IS_BRANCH, BRANCH_ADDR←EX_TARGET, RETURN←EX_IS_RETURN, PREDICTED←~mispredict. Non-resolving advance cycles: BRANCH←0, PREDICTED←1, others hold.
- FSM IDLE: mispredict → SQUASH, cnt←SHADOW, FLUSH←1, all pipeline entries' valid cleared on the same edge.
- FSM SQUASH: each advance decrements cnt; SQUASH_EX=1 combinationally; EX_VALID ignored (no resolve, no counter update); at cnt=1 with advance → IDLE, FLUSH←0. Without advance, cnt and FLUSH hold.
- Counters: BRANCH_COUNT += BRANCH on each resolve with EX_IS_BRANCH; MISPRED_COUNT += 1 on each mispredict of a branch (non-branch mispredicts redirect but are not counted). Both wrap at 2^32.

## Timing
- Reset values: BRANCH 0, BRANCH_TAKEN 0, BRANCH_ADDR 0, EX_PC 0, RETURN 0, PREDICTED 1, FLUSH 0, SQUASH_EX 0, counters 0, all entries invalid, state IDLE.
- RST mid-squash: IDLE next edge, FLUSH 0; RST overrides advance.
- Latency: EX inputs at edge N → update bundle valid after edge N (one cycle), matching the predictor's registered capture.
- Redirect: PREDICTED=0 for exactly one advance cycle per mispredict; FLUSH high for exactly SHADOW advance cycles starting the same cycle.
- Stall (advance=0) freezes all outputs, FSM and counters.
- Fetch entries entering during SQUASH are stored valid (post-redirect path).

## Test plan
- Correct not-taken: IF 0x100/prd 0x104, EX 0x100 not-branch → PREDICTED 1, BRANCH 0, FLUSH 0, counters 0.
- Correct taken: IF 0x200/prd 0x300, EX branch taken target 0x300 → BRANCH 1, BRANCH_TAKEN 1, BRANCH_ADDR 0x300, PREDICTED 1, BRANCH_COUNT 1, MISPRED_COUNT 0.
- Mispredict: IF 0x200/prd 0x204, EX taken to 0x400 → PREDICTED 0 one cycle, FLUSH 2 cycles, SQUASH_EX 2 cycles, next two EX_VALID ignored, MISPRED_COUNT 1.
- Stall during squash: mispredict, then advance=0 for 5 cycles → FLUSH stays 1, cnt frozen, FLUSH drops after 2 total advance cycles.
- Reset mid-squash: RST one cycle into SQUASH → all outputs at reset values next edge, following EX 0x500 correct resolves normally.
- PC mismatch: head pc 0x100, EX_PC_IN 0x108 → mispredict, PREDICTED 0, no MISPRED_COUNT increment if EX_IS_BRANCH=0.
